// File: rtl/tone_pkg.sv
// tone_pkg: shared note table for the tone generators and the tone detector.
// Holds the clock rate, note codes, half-period table (50 MHz clk cycles),
// the state encoding of the detector and the tolerance classifier.
package tone_pkg;
    localparam int CLK_HZ = 50_000_000;
    localparam int HP_W = 19;
    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_SI   = 4'd7;
    localparam logic [3:0] NOTE_DO2  = 4'd8;
    localparam logic [HP_W-1:0] HP_DO  = 19'd95556;
    localparam logic [HP_W-1:0] HP_RE  = 19'd85131;
    localparam logic [HP_W-1:0] HP_MI  = 19'd75843;
    localparam logic [HP_W-1:0] HP_FA  = 19'd71586;
    localparam logic [HP_W-1:0] HP_SOL = 19'd63776;
    localparam logic [HP_W-1:0] HP_LA  = 19'd56818;
    localparam logic [HP_W-1:0] HP_SI  = 19'd50619;
    localparam logic [HP_W-1:0] HP_DO2 = 19'd47778;
    localparam logic [HP_W-1:0] HP_TABLE [1:8] =
        '{HP_DO, HP_RE, HP_MI, HP_FA, HP_SOL, HP_LA, HP_SI, HP_DO2};

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} det_state_t;

    // Lowest note whose half-period is within tol of c; scanning downwards
    // lets the lower index overwrite any higher match.
    function automatic logic [3:0] classify(input logic [HP_W-1:0] c, input int tol);
        logic [3:0] r;
        r = NOTE_NONE;
        for (int k = 8; k >= 1; k--)
            if (int'(c) - int'(HP_TABLE[k]) <= tol && int'(HP_TABLE[k]) - int'(c) <= tol)
                r = 4'(k);
        return r;
    endfunction
endpackage

// File: rtl/tone_sync_edge.sv
// tone_sync_edge: 2-flop synchronizer plus a third flop for edge detection.
// Ports: clk, rst (async, active-high), din (async input),
//        toggle (one-cycle pulse on either edge of the synchronized input).
module tone_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic toggle
);
    logic [2:0] sr;
    always_ff @(posedge clk or posedge rst)
        if (rst) sr <= '0;
        else     sr <= {sr[1:0], din};
    assign toggle = sr[1] ^ sr[2];
endmodule

// File: rtl/tone_detector.sv
// tone_detector: identifies which scale note a square-wave tone carries.
// Ports: clk, rst (async, active-high), tone_in (async square wave),
//        note (0 none, 1..8 Do..Do'), note_valid (locked), half_period (last
//        measured half-period in clk cycles), sample_stb (half_period updated),
//        note_onehot (only when TONE_DET_ONEHOT_EN is defined).
module tone_detector
    import tone_pkg::*;
#(
    parameter int TOL       = 512,
    parameter int MATCH_CNT = 4,
    parameter int TIMEOUT   = 131072
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tone_in,
    output logic [3:0]      note,
    output logic            note_valid,
    output logic [HP_W-1:0] half_period,
    output logic            sample_stb
`ifdef TONE_DET_ONEHOT_EN
    ,
    output logic [7:0]      note_onehot
`endif
);
    localparam logic [HP_W-1:0] TO = HP_W'(TIMEOUT);
    localparam logic [3:0] MC = 4'(MATCH_CNT);

    det_state_t state, state_n;
    logic [HP_W-1:0] cnt;
    logic [3:0] cls, run, run_n, run_adv, prev, prev_n, note_n;
    logic tog, timed_out, restart, measure, valid_n;

    tone_sync_edge u_sync (.clk(clk), .rst(rst), .din(tone_in), .toggle(tog));

    // An edge arriving while idle, or exactly as the counter saturates,
    // only restarts acquisition; its half-period is never measured.
    assign timed_out = cnt == TO;
    assign restart   = tog && (state == IDLE || timed_out);
    assign measure   = tog && !restart;
    assign cls       = classify(half_period, TOL);

    always_ff @(posedge clk or posedge rst)
        if (rst)            cnt <= '0;
        else if (tog)       cnt <= HP_W'(1);
        else if (!timed_out) cnt <= cnt + HP_W'(1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            half_period <= '0;
            sample_stb  <= 1'b0;
        end else begin
            sample_stb <= measure;
            if (measure) half_period <= cnt;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            note       <= NOTE_NONE;
            note_valid <= 1'b0;
            run        <= '0;
            prev       <= NOTE_NONE;
        end else begin
            state      <= state_n;
            note       <= note_n;
            note_valid <= valid_n;
            run        <= run_n;
            prev       <= prev_n;
        end

`ifdef TONE_DET_ONEHOT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) note_onehot <= '0;
        else     note_onehot <= valid_n ? 8'd1 << (note_n - 4'd1) : 8'd0;
`endif

    // Compare stage: runs the cycle after sample_stb on the registered count.
    always_comb begin
        state_n = state;
        note_n  = note;
        valid_n = note_valid;
        run_n   = run;
        prev_n  = prev;
        run_adv = (cls == NOTE_NONE) ? 4'd0 : (cls == prev) ? run + 4'd1 : 4'd1;
        if (restart || timed_out) begin
            state_n = restart ? ACQUIRE : IDLE;
            note_n  = NOTE_NONE;
            valid_n = 1'b0;
            run_n   = '0;
            prev_n  = NOTE_NONE;
        end else if (sample_stb) begin
            prev_n = cls;
            if (!(state == LOCKED && cls == note)) begin
                run_n   = run_adv;
                valid_n = run_adv == MC;
                state_n = valid_n ? LOCKED : ACQUIRE;
                note_n  = valid_n ? cls : NOTE_NONE;
            end
        end
    end
endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: drives square waves of chosen half-periods and checks the
// detector against a model built from the note table and lock/timeout rules.
module tb_tone_detector;
    localparam int TOL = 512, MC = 4, TO = 131072;
    localparam int DO = 95556, SOL = 63776, LA = 56818, SI = 50619, MIS = 64300;

    typedef struct {
        int h;
        int reps;
        int note;
        int valid;
        int hp;
    } step_t;

    logic clk = 1'b0, rst = 1'b1, tone_in = 1'b0;
    logic [3:0] note;
    logic note_valid;
    logic [18:0] half_period;
    logic sample_stb;
`ifdef TONE_DET_ONEHOT_EN
    logic [7:0] note_onehot;
`endif

    int checks = 0, errors = 0;
    int tab [1:8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
    int prev_h = -1;
    int cur_note = 0, cur_valid = 0, cur_hp = 0;
    int cls_q[$];
    step_t steps [17];

    tone_detector #(.TOL(TOL), .MATCH_CNT(MC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .tone_in(tone_in), .note(note), .note_valid(note_valid),
        .half_period(half_period), .sample_stb(sample_stb)
`ifdef TONE_DET_ONEHOT_EN
        , .note_onehot(note_onehot)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input int n, input int v, input int hp);
        chk({nm, " note"}, int'(note), n);
        chk({nm, " valid"}, int'(note_valid), v);
        chk({nm, " half_period"}, int'(half_period), hp);
`ifdef TONE_DET_ONEHOT_EN
        chk({nm, " onehot"}, int'(note_onehot), v != 0 ? 1 << (n - 1) : 0);
`endif
    endtask

    function automatic int ref_class(input int c);
        for (int k = 1; k <= 8; k++)
            if (c - tab[k] <= TOL && tab[k] - c <= TOL) return k;
        return 0;
    endfunction

    // Toggle tone_in (at a negedge), then hold it for h clocks. The edge made
    // here measures the previous half (prev_h). rk != 0 pulses rst at cycle rk.
    task automatic half(input int h, input int rk);
        bit meas;
        int nn, nv, nh, stbs, c;
        meas = prev_h > 0 && prev_h < TO;
        nn = cur_note; nv = cur_valid; nh = cur_hp;
        if (meas) begin
            c = ref_class(prev_h);
            cls_q.push_back(c);
            nh = prev_h;
            nv = 0;
            if (cls_q.size() >= MC) begin
                nv = int'(c != 0);
                for (int i = 1; i <= MC; i++)
                    if (cls_q[cls_q.size() - i] != c) nv = 0;
            end
            nn = nv != 0 ? c : 0;
        end else begin
            cls_q.delete();
            nn = 0; nv = 0;
        end
        tone_in = ~tone_in;
        stbs = 0;
        for (int k = 1; k <= h; k++) begin
            @(negedge clk);
            stbs += int'(sample_stb);
            if (rk == 0 || k < rk) begin
                if (k == 2) chk_out("pre-edge", cur_note, cur_valid, cur_hp);
                if (k == 3) begin
                    chk("stb timing", int'(sample_stb), int'(meas));
                    chk_out("latch", meas ? cur_note : 0, meas ? cur_valid : 0, nh);
                end
                if (k == 4) chk_out("compare", nn, nv, nh);
                if (k == TO + 2) chk_out("pre-timeout", nn, nv, nh);
                if (k == TO + 3) begin
                    cls_q.delete();
                    nn = 0; nv = 0;
                    chk_out("timeout", 0, 0, nh);
                end
            end
            if (k == rk) begin
                #2 rst = 1'b1;
                #1 chk_out("async reset", 0, 0, 0);
                chk("async reset stb", int'(sample_stb), 0);
                cls_q.delete();
                nn = 0; nv = 0; nh = 0;
            end
            if (rk != 0 && k == rk + 2) rst = 1'b0;
        end
        chk("stb count", stbs, int'(meas && (rk == 0 || rk > 3)));
        chk_out("half end", nn, nv, nh);
        cur_note = nn; cur_valid = nv; cur_hp = nh;
        prev_h = rk != 0 ? -1 : h;
    endtask

    initial begin
        int stbs, c;
        steps = '{
            '{SOL, 1, 0, 0, 0},       '{SOL, 3, 0, 0, SOL},    '{SOL, 1, 5, 1, SOL},
            '{LA, 1, 5, 1, SOL},      '{LA, 1, 0, 0, LA},      '{LA, 2, 0, 0, LA},
            '{MIS, 1, 6, 1, LA},      '{MIS, 1, 0, 0, MIS},    '{MIS, 4, 0, 0, MIS},
            '{DO, 1, 0, 0, MIS},      '{DO, 3, 0, 0, DO},      '{DO, 1, 1, 1, DO},
            '{TO + 10, 1, 0, 0, DO},  '{TO - 1, 1, 0, 0, DO},  '{TO, 1, 0, 0, TO - 1},
            '{SI, 1, 0, 0, TO - 1},   '{SI, 4, 7, 1, SI}
        };
        repeat (3) @(negedge clk);
        chk_out("reset", 0, 0, 0);
        chk("reset stb", int'(sample_stb), 0);
        rst = 1'b0;
        stbs = 0;
        repeat (200000) begin
            @(negedge clk);
            stbs += int'(sample_stb);
        end
        chk("idle stb count", stbs, 0);
        chk_out("idle", 0, 0, 0);

        foreach (steps[i]) begin
            repeat (steps[i].reps) half(steps[i].h, 0);
            chk_out($sformatf("step%0d", i), steps[i].note, steps[i].valid, steps[i].hp);
        end

        if (!tone_in) half(SI, 0);
        half(SI, 20000);
        chk_out("post-reset", 0, 0, 0);
        repeat (4) half(SI, 0);
        chk_out("relock wait", 0, 0, SI);
        half(SI, 0);
        chk_out("relock", 7, 1, SI);
        half(SI - 512, 0);
        half(SI, 0);
        chk_out("tol edge in", 7, 1, SI - 512);
        half(SI + 513, 0);
        half(SI, 0);
        chk_out("tol edge out", 0, 0, SI + 513);

        c = 5;
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(3) == 0) c = int'($urandom_range(8, 1));
            half(tab[c] + int'($urandom_range(1400)) - 700, 0);
        end
        for (int i = 0; i < 40; i++) half(int'($urandom_range(3000, 5)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
- Listening end of the piano tone path: takes a square-wave tone (as produced by the note generators driving the speaker, 50 MHz system clock) and identifies which of the eight scale notes it is.
- Measures half-periods between edges, classifies each against a constant table, and asserts a note code once the tone is stable.
- Sits next to the note generators for loop-back self-test and for LED/display readout.

Parameters:
- TOL, 512, allowed ± deviation in clk cycles between a measured half-period and a table entry.
- MATCH_CNT, 4, consecutive same-class half-periods required to lock (range 1..15).
- TIMEOUT, 131072, clk cycles without an edge before declaring silence (must exceed longest table entry).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous reset, active-high.
- tone_in  input  1  asynchronous square-wave tone.
- note  output  4  0 = none, 1..8 = Do, Re, Mi, Fa, Sol, La, Si, Do'.
- note_valid  output  1  high while locked on a note.
- half_period  output  19  last measured half-period in clk cycles.
- sample_stb  output  1  one-cycle pulse when half_period updates.

Behaviour:
- Reset (async, active-high): note=0, note_valid=0, half_period=0, sample_stb=0, counter=0, run=0, state=IDLE, synchronizer flops=0.
- Input path: 2-flop synchronizer, then a third flop for edge detect. Both rising and falling edges count.
- Counter: 19-bit, increments every clk, saturates at TIMEOUT, and clears to 1 on each edge (the edge cycle counts as cycle 1 of the next half-period).
- Table (half-period cycles):
  - Do 95556, Re 85131, Mi 75843, Fa 71586.
  - Sol 63776, La 56818, Si 50619, Do' 47778.
- Classification of a measured count c: class = lowest index k with |c − table[k]| ≤ TOL, else 0. The compare stage is registered.
- States:
  - IDLE:
    - First edge → ACQUIRE, run=0.
    - No half_period or sample_stb update on this edge.
  - ACQUIRE: each edge latches half_period=counter and pulses sample_stb. Then, in the compare cycle:
    - class≠0 and class==prev_class → run++.
    - class≠0 and class≠prev_class → run=1.
    - class==0 → run=0.
    - When run reaches MATCH_CNT → LOCKED, note=class, note_valid=1.
  - LOCKED:
    - Each edge latches and strobes as in ACQUIRE.
    - class==note → stay.
    - Any other class, including 0 → ACQUIRE, note_valid=0, note=0, run set as above.
  - Any state: counter reaches TIMEOUT → IDLE, note=0, note_valid=0, run=0. half_period keeps its last value.
- Latency:
  - tone_in edge → sample_stb: 3 clk (2 sync + 1 edge detect/latch).
  - note/note_valid update: 1 clk after the corresponding sample_stb.
- Edge on the same cycle as TIMEOUT: the edge wins. Counter restarts, state goes to ACQUIRE, and that edge is not measured.
- Counter never wraps; measured value is at most TIMEOUT−1 when in ACQUIRE/LOCKED.
- Reset asserted mid-lock: outputs clear immediately (asynchronously).

Optional Feature:
- TONE_DET_ONEHOT_EN defined:
  - Adds output port note_onehot [7:0].
  - Bit note−1 is high while note_valid; otherwise 0.
  - Registered alongside note, reset 0.
- Not defined: port and logic absent; all other behaviour identical.

Decomposition:
- Package tone_pkg holds:
  - CLK_HZ=50_000_000.
  - Note code constants NOTE_NONE..NOTE_DO2.
  - The eight half-period constants.
  - Width constant HP_W=19.
- The package is shared with the note generators so both ends use one table.
- One sub-module, tone_sync_edge: 2-flop synchronizer plus edge-pulse output.

Test Plan:
- Reset, tone_in static 0 → note=0, note_valid=0, no sample_stb for 200000 cycles.
- Square wave of 63776-cycle half-periods (Sol):
  - sample_stb 3 clk after each edge, half_period=63776.
  - note=5 and note_valid=1 one clk after the 5th edge (1 start + 4 matches).
- Locked on Sol, then switch to 56818-cycle half-periods (La) → note_valid drops after the first La half-period; note=6 after 4 La half-periods.
- Half-periods of 64300 (mismatch >TOL from Sol) → run stays 0, note_valid never asserts, half_period=64300.
- Locked on Do (95556), tone_in held constant → note_valid=0 and state IDLE exactly TIMEOUT cycles after the last edge.
- Locked on Si (50619), assert rst mid-half-period → all outputs 0 within the same cycle; after release, relock takes 5 edges.
